// File: rtl/hazard_unit_v2.sv
// hazard_unit_v2: load-use/RAW stall detection plus a small branch FSM with an
// optional 2-bit-counter branch history table.
// Optional feature macro: BHT_PREDICT_EN (builds the BHT; otherwise predict
// not-taken, so every taken branch recovers through FLUSH).
module hazard_unit_v2 #(
    parameter int                     IW           = 16,
    parameter int                     OPW          = 3,
    parameter int                     RW           = 3,
    parameter logic [(1<<OPW)-1:0]    TWO_SRC_MASK = 8'b0100_0101,
    parameter int                     BEQ_OP       = 2,
    parameter int                     BHT_DEPTH    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IW-1:0] ifid_instr,
    input  logic [15:0]   ifid_pc,
    input  logic          idex_write,
    input  logic          exmem_write,
    input  logic [RW-1:0] idex_wreg,
    input  logic [RW-1:0] exmem_wreg,
    input  logic          br_resolve,
    input  logic          br_taken,
    input  logic [15:0]   br_pc,
    output logic          pc_stall,
    output logic          predict_taken,
    output logic          mispredict,
    output logic          ifid_flush,
    output logic [1:0]    fsm_state,
    output logic [15:0]   stall_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BRANCH = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam int IDXW = $clog2(BHT_DEPTH);

    state_t         state;
    logic           pred_q;
    logic [OPW-1:0] opcode;
    logic [RW-1:0]  rs;
    logic [RW-1:0]  rt;
    logic           two_src;
    logic           rs_haz;
    logic           rt_haz;
    logic           hazard;
    logic           is_beq;
    logic           bht_upd;

    // Field decode: opcode on top, then rs, then rt.
    assign opcode  = ifid_instr[IW-1 -: OPW];
    assign rs      = ifid_instr[IW-OPW-1 -: RW];
    assign rt      = ifid_instr[IW-OPW-RW-1 -: RW];
    assign two_src = TWO_SRC_MASK[opcode];
    assign is_beq  = (opcode == OPW'(BEQ_OP));

    // r0 is hardwired zero, so it never creates a dependency.
    assign rs_haz = (rs != '0) &&
                    ((idex_write && rs == idex_wreg) || (exmem_write && rs == exmem_wreg));
    assign rt_haz = two_src && (rt != '0) &&
                    ((idex_write && rt == idex_wreg) || (exmem_write && rt == exmem_wreg));
    assign hazard = rs_haz || rt_haz;

    // Reset freezes fetch; FLUSH lets the redirected fetch through regardless.
    assign pc_stall  = reset ? 1'b1 : (state == FLUSH) ? 1'b0 : hazard;
    assign fsm_state = state;

    // Resolves are only meaningful while a predicted branch is outstanding.
    assign bht_upd = (state == BRANCH) && br_resolve;

`ifdef BHT_PREDICT_EN
    logic [BHT_DEPTH-1:0][1:0] bht;
    logic [IDXW-1:0]           upd_idx;
    logic [IDXW-1:0]           lkp_idx;

    assign upd_idx = br_pc[IDXW-1:0];
    assign lkp_idx = ifid_pc[IDXW-1:0];

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign predict_taken = bht[lkp_idx][1];

    // Saturating 2-bit counters, reset to weakly not-taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (bht_upd) begin
            if (br_taken && bht[upd_idx] != 2'b11)
                bht[upd_idx] <= bht[upd_idx] + 2'd1;
            else if (!br_taken && bht[upd_idx] != 2'b00)
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
        end
    end
`else
    assign predict_taken = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{ifid_pc, br_pc, ifid_instr, bht_upd};

    // Branch FSM with registered recovery pulses (high exactly while in FLUSH).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pred_q     <= 1'b0;
            mispredict <= 1'b0;
            ifid_flush <= 1'b0;
        end else begin
            mispredict <= 1'b0;
            ifid_flush <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_beq && !hazard) begin
                        state  <= BRANCH;
                        pred_q <= predict_taken;
                    end
                end
                BRANCH: begin
                    if (br_resolve) begin
                        if (br_taken != pred_q) begin
                            state      <= FLUSH;
                            mispredict <= 1'b1;
                            ifid_flush <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_count <= 16'd0;
        else if (pc_stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Directed bench for hazard_unit_v2; expectations queued at drive time and
// popped at each sample point. Works with or without BHT_PREDICT_EN.
module tb_hazard_unit_v2;

    localparam logic [1:0] S_IDLE = 2'd0, S_BRANCH = 2'd1, S_FLUSH = 2'd2;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        idex_write, exmem_write;
    logic [2:0]  idex_wreg, exmem_wreg;
    logic        br_resolve, br_taken;
    logic [15:0] br_pc;
    logic        pc_stall, predict_taken, mispredict, ifid_flush;
    logic [1:0]  fsm_state;
    logic [15:0] stall_count;

    hazard_unit_v2 dut (
        .clock(clock), .reset(reset), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .idex_write(idex_write), .exmem_write(exmem_write),
        .idex_wreg(idex_wreg), .exmem_wreg(exmem_wreg),
        .br_resolve(br_resolve), .br_taken(br_taken), .br_pc(br_pc),
        .pc_stall(pc_stall), .predict_taken(predict_taken),
        .mispredict(mispredict), .ifid_flush(ifid_flush),
        .fsm_state(fsm_state), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic        stall;
        logic        pred;
        logic [1:0]  st;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] m_cnt    = 16'd0;
    logic        m_stall  = 1'b1;
    logic [1:0]  m_bht[8];

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt);
        return {op, rs, rt, 7'b0};
    endfunction

    function automatic logic m_pred(input logic [15:0] pc);
`ifdef BHT_PREDICT_EN
        return m_bht[pc[2:0]][1];
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_update(input logic [15:0] pc, input logic taken);
        if (taken && m_bht[pc[2:0]] != 2'b11) m_bht[pc[2:0]] = m_bht[pc[2:0]] + 2'd1;
        else if (!taken && m_bht[pc[2:0]] != 2'b00) m_bht[pc[2:0]] = m_bht[pc[2:0]] - 2'd1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_bht[i] = 2'b01;
        m_cnt = 16'd0;
    endtask

    task automatic push(input string tag, input logic stall, input logic pred,
                        input logic [1:0] st, input logic mis);
        exp_t e;
        e.tag = tag; e.stall = stall; e.pred = pred; e.st = st; e.mis = mis; e.cnt = m_cnt;
        sbq.push_back(e);
        m_stall = stall;
    endtask

    task automatic sample();
        exp_t e;
        #1;
        if (sbq.size() == 0) begin
            n_assert++; n_fail++;
            $display("FAIL sb_empty observed=0 entries required>=1");
            return;
        end
        e = sbq.pop_front();
        n_assert++;
        assert (pc_stall === e.stall) else begin n_fail++;
            $error("FAIL %s pc_stall observed=%b expected=%b", e.tag, pc_stall, e.stall); end
        n_assert++;
        assert (predict_taken === e.pred) else begin n_fail++;
            $error("FAIL %s predict_taken observed=%b expected=%b", e.tag, predict_taken, e.pred); end
        n_assert++;
        assert (fsm_state === e.st) else begin n_fail++;
            $error("FAIL %s fsm_state observed=%0d expected=%0d", e.tag, fsm_state, e.st); end
        n_assert++;
        assert (mispredict === e.mis && ifid_flush === e.mis) else begin n_fail++;
            $error("FAIL %s mispredict/ifid_flush observed=%b/%b expected=%b", e.tag, mispredict, ifid_flush, e.mis); end
        n_assert++;
        assert (stall_count === e.cnt) else begin n_fail++;
            $error("FAIL %s stall_count observed=%0d expected=%0d", e.tag, stall_count, e.cnt); end
    endtask

    // One clock edge; the bench's own count follows the expected pc_stall.
    task automatic tick();
        @(posedge clock);
        if (!reset && m_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        #1;
    endtask

    // Full branch: issue BEQ at pc, resolve with 'taken', recover if needed.
    task automatic do_branch(input string tag, input logic [15:0] pc, input logic taken);
        logic p;
        ifid_instr = mk(3'd2, 3'd1, 3'd2); ifid_pc = pc; br_resolve = 1'b0;
        p = m_pred(pc);
        push({tag, "_lookup"}, 1'b0, p, S_IDLE, 1'b0); sample();
        tick();
        ifid_instr = mk(3'd1, 3'd0, 3'd0);
        br_resolve = 1'b1; br_taken = taken; br_pc = pc;
        push({tag, "_resolve"}, 1'b0, m_pred(pc), S_BRANCH, 1'b0); sample();
        tick();
        m_update(pc, taken);
        br_resolve = 1'b0;
        if (taken != p) begin
            push({tag, "_flush"}, 1'b0, m_pred(pc), S_FLUSH, 1'b1); sample();
            tick();
        end
        push({tag, "_done"}, 1'b0, m_pred(pc), S_IDLE, 1'b0); sample();
    endtask

    initial begin
        m_reset();
        reset = 1'b1; ifid_instr = '0; ifid_pc = '0;
        idex_write = 0; exmem_write = 0; idex_wreg = 0; exmem_wreg = 0;
        br_resolve = 0; br_taken = 0; br_pc = '0;

        // Reset state and hold
        push("rst", 1'b1, 1'b0, S_IDLE, 1'b0); sample();
        tick(); tick();
        push("rst_hold", 1'b1, 1'b0, S_IDLE, 1'b0); sample();
        reset = 1'b0;
        push("idle", 1'b0, m_pred(0), S_IDLE, 1'b0); sample();

        // EX/MEM dependency on rs
        ifid_instr = mk(3'd1, 3'd3, 3'd0); exmem_write = 1; exmem_wreg = 3'd3;
        push("exmem_rs", 1'b1, m_pred(0), S_IDLE, 1'b0); sample();
        tick();
        push("exmem_cnt", 1'b1, m_pred(0), S_IDLE, 1'b0); sample();
        tick();
        ifid_instr = mk(3'd1, 3'd0, 3'd0); exmem_wreg = 3'd0;
        push("rs_zero", 1'b0, m_pred(0), S_IDLE, 1'b0); sample();
        tick();
        push("cnt_hold", 1'b0, m_pred(0), S_IDLE, 1'b0); sample();

        // ID/EX dependency on rt: two-source vs rs-only opcode, and rt = r0
        exmem_write = 0; idex_write = 1; idex_wreg = 3'd5;
        ifid_instr = mk(3'd0, 3'd1, 3'd5);
        push("rtype_rt", 1'b1, m_pred(0), S_IDLE, 1'b0); sample();
        ifid_instr = mk(3'd6, 3'd1, 3'd5);
        push("op6_rt", 1'b1, m_pred(0), S_IDLE, 1'b0); sample();
        ifid_instr = mk(3'd1, 3'd1, 3'd5);
        push("rsonly_rt", 1'b0, m_pred(0), S_IDLE, 1'b0); sample();
        idex_wreg = 3'd0; ifid_instr = mk(3'd0, 3'd0, 3'd0);
        push("rt_zero", 1'b0, m_pred(0), S_IDLE, 1'b0); sample();
        tick();
        idex_write = 0;

        // Resolve in IDLE must be ignored (would disturb pc=1 entry)
        br_resolve = 1; br_taken = 1; br_pc = 16'd1;
        push("idle_resolve", 1'b0, m_pred(0), S_IDLE, 1'b0); sample();
        tick();
        br_resolve = 0;

        // First BEQ at pc=4: hold in BRANCH, resolve taken, FLUSH pulse
        ifid_instr = mk(3'd2, 3'd1, 3'd2); ifid_pc = 16'd4;
        push("beq4_lookup", 1'b0, m_pred(4), S_IDLE, 1'b0); sample();
        tick();
        ifid_instr = mk(3'd1, 3'd0, 3'd0);
        push("branch_hold", 1'b0, m_pred(4), S_BRANCH, 1'b0); sample();
        tick();
        push("branch_hold2", 1'b0, m_pred(4), S_BRANCH, 1'b0); sample();
        br_resolve = 1; br_taken = 1; br_pc = 16'd4;
        push("resolve_pre", 1'b0, m_pred(4), S_BRANCH, 1'b0); sample();
        tick();
        m_update(16'd4, 1'b1);
        // Hazard present and a stray resolve during FLUSH
        ifid_instr = mk(3'd1, 3'd3, 3'd0); exmem_write = 1; exmem_wreg = 3'd3; br_taken = 0;
        push("flush_pulse", 1'b0, m_pred(4), S_FLUSH, 1'b1); sample();
        tick();
        push("post_flush", 1'b1, m_pred(4), S_IDLE, 1'b0); sample();
        tick();
        exmem_write = 0; br_resolve = 0;
        do_branch("beq4_again", 16'd4, 1'b1);

        // Saturation at pc=1, then step back down
        for (int i = 0; i < 4; i++) do_branch("pc1_taken", 16'd1, 1'b1);
        do_branch("pc1_nt1", 16'd1, 1'b0);
        do_branch("pc1_nt2", 16'd1, 1'b0);
        do_branch("pc3_nt", 16'd3, 1'b0);

        // Reset during BRANCH aborts the branch and clears the table
        ifid_instr = mk(3'd2, 3'd1, 3'd2); ifid_pc = 16'd6;
        push("beq6_lookup", 1'b0, m_pred(6), S_IDLE, 1'b0); sample();
        tick();
        ifid_instr = mk(3'd1, 3'd0, 3'd0);
        push("beq6_branch", 1'b0, m_pred(6), S_BRANCH, 1'b0); sample();
        reset = 1; br_resolve = 1; br_taken = 1; br_pc = 16'd6;
        m_reset();
        push("rst_abort", 1'b1, m_pred(6), S_IDLE, 1'b0); sample();
        tick();
        push("rst_abort_hold", 1'b1, m_pred(6), S_IDLE, 1'b0); sample();
        reset = 0; br_resolve = 0; ifid_pc = 16'd4;
        push("bht_cleared", 1'b0, m_pred(4), S_IDLE, 1'b0); sample();
        tick();
        push("no_mispredict", 1'b0, m_pred(4), S_IDLE, 1'b0); sample();
        do_branch("post_rst_pc4", 16'd4, 1'b1);

        n_assert++;
        assert (sbq.size() == 0) else begin n_fail++;
            $error("FAIL sb_drain observed=%0d entries expected=0", sbq.size()); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
